// File: rtl/elevator_countdown.sv
// elevator_countdown: dwell/travel countdown in whole seconds for the elevator controller.
// Drives the remaining-seconds display value, a one-cycle dwell_done pulse and a
// one-cycle floor_step pulse per travel period.
// Optional feature: define DOOR_HOLD_EN to let the hold input freeze the dwell count.
module elevator_countdown #(
    parameter int unsigned CLK_HZ     = 10000,
    parameter int unsigned DWELL_SEC  = 5,
    parameter int unsigned TRAVEL_SEC = 5,
    parameter int unsigned VAL_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             restart,
    input  logic             hold,
    output logic [VAL_W-1:0] counting_value,
    output logic             dwell_done,
    output logic             floor_step
);

    localparam int unsigned SUB_W = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;

    localparam logic [SUB_W-1:0] SUB_MAX  = SUB_W'(CLK_HZ - 1);
    localparam logic [VAL_W-1:0] DWELL_V  = VAL_W'(DWELL_SEC);
    localparam logic [VAL_W-1:0] TRAVEL_V = VAL_W'(TRAVEL_SEC);

    localparam logic [1:0] MODE_DWELL  = 2'd1;
    localparam logic [1:0] MODE_TRAVEL = 2'd2;

    logic [SUB_W-1:0] sub_cnt;
    logic [SUB_W-1:0] sub_nxt;
    logic [VAL_W-1:0] sec_cnt;
    logic [VAL_W-1:0] sec_nxt;
    logic [1:0]       mode_q;
    logic             dwell_done_nxt;
    logic             floor_step_nxt;
    logic             hold_act;

`ifdef DOOR_HOLD_EN
    assign hold_act = hold;
`else
    // hold is kept on the port for pin compatibility but has no effect in this build
    logic unused_hold;
    assign unused_hold = hold;
    assign hold_act    = 1'b0;
`endif

    // Next-state and pulse computation for the prescaler and the seconds counter
    always_comb begin
        sub_nxt        = sub_cnt;
        sec_nxt        = sec_cnt;
        dwell_done_nxt = 1'b0;
        floor_step_nxt = 1'b0;

        if (mode != mode_q) begin
            // Any mode change reloads; the load beats any coincident expiry or step
            sub_nxt = SUB_MAX;
            sec_nxt = (mode == MODE_TRAVEL) ? TRAVEL_V : DWELL_V;
        end else begin
            case (mode)
                MODE_DWELL: begin
                    if (restart) begin
                        sub_nxt = SUB_MAX;
                        sec_nxt = DWELL_V;
                    end else if (hold_act) begin
                        sub_nxt = sub_cnt;
                        sec_nxt = sec_cnt;
                    end else if (sec_cnt == '0) begin
                        sec_nxt = '0;
                    end else if (sub_cnt != '0) begin
                        sub_nxt = sub_cnt - SUB_W'(1);
                    end else begin
                        sub_nxt        = SUB_MAX;
                        sec_nxt        = sec_cnt - VAL_W'(1);
                        dwell_done_nxt = (sec_cnt == VAL_W'(1));
                    end
                end
                MODE_TRAVEL: begin
                    if (sub_cnt != '0) begin
                        sub_nxt = sub_cnt - SUB_W'(1);
                    end else if (sec_cnt <= VAL_W'(1)) begin
                        // End of one floor: wrap back to the full travel time
                        sub_nxt        = SUB_MAX;
                        sec_nxt        = TRAVEL_V;
                        floor_step_nxt = 1'b1;
                    end else begin
                        sub_nxt = SUB_MAX;
                        sec_nxt = sec_cnt - VAL_W'(1);
                    end
                end
                default: begin
                    sub_nxt = SUB_MAX;
                    sec_nxt = DWELL_V;
                end
            endcase
        end
    end

    // Counter, previous-mode and pulse registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sub_cnt    <= SUB_MAX;
            sec_cnt    <= DWELL_V;
            mode_q     <= 2'd0;
            dwell_done <= 1'b0;
            floor_step <= 1'b0;
        end else begin
            sub_cnt    <= sub_nxt;
            sec_cnt    <= sec_nxt;
            mode_q     <= mode;
            dwell_done <= dwell_done_nxt;
            floor_step <= floor_step_nxt;
        end
    end

    assign counting_value = sec_cnt;

endmodule

// File: tb/tb_elevator_countdown.sv
// Scoreboard bench for elevator_countdown (CLK_HZ=10, DWELL_SEC=5, TRAVEL_SEC=3).
module tb_elevator_countdown;

    localparam int unsigned HZ    = 10;
    localparam int unsigned DW    = 5;
    localparam int unsigned TR    = 3;
    localparam int unsigned VAL_W = 3;

    typedef struct {
        logic [VAL_W-1:0] v;
        logic             dd;
        logic             fs;
        string            tag;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [1:0]       mode;
    logic             restart;
    logic             hold;
    logic [VAL_W-1:0] counting_value;
    logic             dwell_done;
    logic             floor_step;

    int   n_tests;
    int   n_fail;
    exp_t q[$];

    elevator_countdown #(
        .CLK_HZ    (HZ),
        .DWELL_SEC (DW),
        .TRAVEL_SEC(TR),
        .VAL_W     (VAL_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mode          (mode),
        .restart       (restart),
        .hold          (hold),
        .counting_value(counting_value),
        .dwell_done    (dwell_done),
        .floor_step    (floor_step)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected dwell display k edges after a load/restart edge
    function automatic int dv(input int k);
        return (k < int'(DW * HZ)) ? int'(DW) - k / int'(HZ) : 0;
    endfunction

    function automatic logic dd_at(input int k);
        return (k == int'(DW * HZ));
    endfunction

    // Expected travel display and step pulse k edges after the travel load edge
    function automatic int tv(input int k);
        return int'(TR) - (k % int'(TR * HZ)) / int'(HZ);
    endfunction

    function automatic logic fs_at(input int k);
        return (k > 0) && (k % int'(TR * HZ) == 0);
    endfunction

    // Drive one cycle of inputs and queue what the DUT must show after the next edge
    task automatic cyc(input logic [1:0] m, input logic r, input logic h,
                       input int v, input logic edd, input logic efs, input string tag);
        exp_t e;
        @(negedge clk);
        mode    = m;
        restart = r;
        hold    = h;
        e.v     = VAL_W'(v);
        e.dd    = edd;
        e.fs    = efs;
        e.tag   = tag;
        q.push_back(e);
    endtask

    task automatic check_now(input string tag, input int v, input logic edd, input logic efs);
        n_tests++;
        if (counting_value !== VAL_W'(v) || dwell_done !== edd || floor_step !== efs) begin
            n_fail++;
            $display("FAIL %s: got val=%0d dd=%0b fs=%0b, want val=%0d dd=%0b fs=%0b",
                     tag, counting_value, dwell_done, floor_step, v, edd, efs);
        end
    endtask

    // Monitor: compare the DUT against the oldest queued expectation after each edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_tests++;
                if (counting_value !== e.v || dwell_done !== e.dd || floor_step !== e.fs) begin
                    n_fail++;
                    $display("FAIL %s: got val=%0d dd=%0b fs=%0b, want val=%0d dd=%0b fs=%0b",
                             e.tag, counting_value, dwell_done, floor_step, e.v, e.dd, e.fs);
                end
            end
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        mode    = 2'd0;
        restart = 1'b0;
        hold    = 1'b0;
        rst     = 1'b1;
        #1 rst  = 1'b0;
        #2 check_now("reset_state", 5, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 3; i++) cyc(2'd0, 1'b0, 1'b0, 5, 1'b0, 1'b0, "idle");
        cyc(2'd3, 1'b0, 1'b0, 5, 1'b0, 1'b0, "mode3_idle");
        cyc(2'd0, 1'b0, 1'b0, 5, 1'b0, 1'b0, "idle");

        // Full dwell: 5..1 for 10 cycles each, pulse at 50, then saturate at 0
        for (int k = 0; k <= 60; k++) cyc(2'd1, 1'b0, 1'b0, dv(k), dd_at(k), 1'b0, "dwell");
        cyc(2'd0, 1'b0, 1'b0, 5, 1'b0, 1'b0, "dwell_to_idle");
        cyc(2'd0, 1'b0, 1'b0, 5, 1'b0, 1'b0, "idle");

        // Restart while showing 2, then restart exactly on the 1 -> 0 boundary
        for (int k = 0; k <= 31; k++) cyc(2'd1, 1'b0, 1'b0, dv(k), dd_at(k), 1'b0, "dwell_pre_restart");
        cyc(2'd1, 1'b1, 1'b0, 5, 1'b0, 1'b0, "restart_at_2");
        for (int k = 1; k <= 49; k++) cyc(2'd1, 1'b0, 1'b0, dv(k), dd_at(k), 1'b0, "dwell_post_restart");
        cyc(2'd1, 1'b1, 1'b0, 5, 1'b0, 1'b0, "restart_at_expiry");
        for (int k = 1; k <= 5; k++) cyc(2'd1, 1'b0, 1'b0, dv(k), dd_at(k), 1'b0, "dwell_after_expiry_restart");
        cyc(2'd0, 1'b0, 1'b0, 5, 1'b0, 1'b0, "idle");

        // Travel: steps at 30/60/90/..., restart ignored, mode change on a step boundary
        for (int k = 0; k <= 119; k++)
            cyc(2'd2, (k == 45), 1'b0, tv(k), 1'b0, fs_at(k), "travel");
        cyc(2'd1, 1'b0, 1'b0, 5, 1'b0, 1'b0, "travel_to_dwell");
        for (int k = 1; k <= 12; k++) cyc(2'd1, 1'b0, 1'b0, dv(k), dd_at(k), 1'b0, "dwell_after_travel");
        cyc(2'd0, 1'b0, 1'b0, 5, 1'b0, 1'b0, "dwell_to_idle2");
        for (int i = 0; i < 3; i++) cyc(2'd0, 1'b0, 1'b0, 5, 1'b0, 1'b0, "idle_frozen");

        // Asynchronous reset while the dwell shows 3
        for (int k = 0; k <= 25; k++) cyc(2'd1, 1'b0, 1'b0, dv(k), dd_at(k), 1'b0, "dwell_pre_reset");
        @(posedge clk);
        #3 rst = 1'b0;
        #1 check_now("async_reset", 5, 1'b0, 1'b0);
        cyc(2'd1, 1'b0, 1'b0, 5, 1'b0, 1'b0, "in_reset");
        cyc(2'd1, 1'b0, 1'b0, 5, 1'b0, 1'b0, "in_reset");
        cyc(2'd1, 1'b0, 1'b0, 5, 1'b0, 1'b0, "reload_after_reset");
        rst = 1'b1;
        for (int k = 1; k <= 15; k++) cyc(2'd1, 1'b0, 1'b0, dv(k), dd_at(k), 1'b0, "dwell_after_reset");
        cyc(2'd0, 1'b0, 1'b0, 5, 1'b0, 1'b0, "idle");

        // Door hold while the dwell shows 3 with 5 sub-counts already elapsed
        for (int k = 0; k <= 25; k++) cyc(2'd1, 1'b0, 1'b0, dv(k), dd_at(k), 1'b0, "dwell_pre_hold");
`ifdef DOOR_HOLD_EN
        for (int i = 0; i < 40; i++) cyc(2'd1, 1'b0, 1'b1, 3, 1'b0, 1'b0, "hold_freeze");
        for (int k = 26; k <= 60; k++) cyc(2'd1, 1'b0, 1'b0, dv(k), dd_at(k), 1'b0, "after_hold");
`else
        for (int k = 26; k <= 60; k++) cyc(2'd1, 1'b0, 1'b1, dv(k), dd_at(k), 1'b0, "hold_ignored");
`endif
        cyc(2'd0, 1'b0, 1'b0, 5, 1'b0, 1'b0, "idle_end");

        // Let the monitor drain the queue, bounded
        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
